// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit in front of the data RAM.
//   lsu_size_e  : access size encoding (B/H/W/D)
//   lsu_state_e : controller state encoding
//   is_misaligned / size_mask : alignment test and unshifted lane mask
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_READ  = 2'd1,
    LSU_WRITE = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] addr);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = addr[0] != 1'b0;
      SZ_W:    mis = addr[1:0] != 2'b00;
      SZ_D:    mis = addr != 3'b000;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [63:0] size_mask(input lsu_size_e size);
    logic [63:0] m;
    m = 64'h0000_0000_0000_00FF;
    case (size)
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      SZ_D:    m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_00FF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Byte-lane alignment between a 64-bit RAM word and a B/H/W/D access.
// Purely combinational; also intended for the cache refill path.
//   addr_i      : byte offset inside the doubleword
//   size_i      : access size (lsu_size_e encoding)
//   unsigned_i  : zero-extend loads when 1
//   old_i       : doubleword currently in RAM
//   wdata_i     : right-justified store data
//   merged_o    : old_i with the addressed lanes replaced by wdata_i
//   load_data_o : addressed lanes shifted down and extended to 64 bits
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] old_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] merged_o,
  output logic [63:0] load_data_o
);

  lsu_size_e   size;
  logic [5:0]  shift;
  logic [63:0] mask;
  logic [31:0] shifted;

  assign size  = lsu_size_e'(size_i);
  assign shift = {addr_i, 3'b000};
  assign mask  = size_mask(size) << shift;

  assign merged_o = (old_i & ~mask) | ((wdata_i << shift) & mask);

  // Only the low word of the shifted value is ever needed; D bypasses it.
  assign shifted = 32'(old_i >> shift);

  always_comb begin
    load_data_o = old_i;
    case (size)
      SZ_B:    load_data_o = {{56{~unsigned_i & shifted[7]}},  shifted[7:0]};
      SZ_H:    load_data_o = {{48{~unsigned_i & shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data_o = {{32{~unsigned_i & shifted[31]}}, shifted[31:0]};
      default: load_data_o = old_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit directly upstream of the data RAM wrapper. Takes one
// B/H/W/D request at a time; sub-doubleword stores are read-modify-write
// because the RAM has no byte enables. Misaligned requests are answered
// with resp_err_o and never reach the RAM.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   req_*_i / req_ready_o     : request handshake from the MEM stage
//   resp_valid_o/_rdata_o/_err_o : one-cycle completion
//   ram_*                     : RAM port (doubleword addressed, latency RD_LATENCY)
//
// state      | meaning
// -----------+-----------------------------------------------------
// LSU_IDLE   | ready for a request
// LSU_READ   | reading the target doubleword, RD_LATENCY+1 cycles
// LSU_WRITE  | single-cycle write of the merged doubleword
// LSU_RESP   | resp_valid_o pulse, then back to idle
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [63:0] ram_raddr_o,
  output logic [63:0] ram_waddr_o,
  output logic [63:0] ram_wdata_o,
  input  logic [63:0] ram_rdata_i
);

  lsu_state_e  state_q;
  logic [1:0]  cnt_q;
  logic        we_q;
  logic [63:0] addr_q;
  lsu_size_e   size_q;
  logic        unsigned_q;
  logic [63:0] wdata_q;
  logic [63:0] old_q;
  logic        err_q;
  logic        resp_valid_q;
  logic        ram_ce_q;
  logic        ram_we_q;
  logic [63:0] merged;
  logic [63:0] load_data;
  lsu_size_e   req_size;

  assign req_size = lsu_size_e'(req_size_i);

  lsu_lane_align u_align (
    .addr_i      (addr_q[2:0]),
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .old_i       (old_q),
    .wdata_i     (wdata_q),
    .merged_o    (merged),
    .load_data_o (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= 2'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= SZ_B;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      old_q        <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (req_valid_i) begin
            we_q       <= req_we_i;
            addr_q     <= req_addr_i;
            size_q     <= req_size;
            unsigned_q <= req_unsigned_i;
            wdata_q    <= req_wdata_i;
            err_q      <= is_misaligned(req_size, req_addr_i[2:0]);
            if (is_misaligned(req_size, req_addr_i[2:0])) begin
              state_q      <= LSU_RESP;
              resp_valid_q <= 1'b1;
            end else if (req_we_i && req_size == SZ_D) begin
              // Full doubleword store needs no old data.
              state_q  <= LSU_WRITE;
              ram_ce_q <= 1'b1;
              ram_we_q <= 1'b1;
            end else begin
              state_q  <= LSU_READ;
              cnt_q    <= 2'(RD_LATENCY);
              ram_ce_q <= 1'b1;
            end
          end
        end
        LSU_READ: begin
          ram_ce_q <= 1'b1;
          if (cnt_q == 2'd0) begin
            old_q <= ram_rdata_i;
            if (we_q) begin
              state_q  <= LSU_WRITE;
              ram_we_q <= 1'b1;
            end else begin
              state_q      <= LSU_RESP;
              ram_ce_q     <= 1'b0;
              resp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        LSU_WRITE: begin
          state_q      <= LSU_RESP;
          resp_valid_q <= 1'b1;
        end
        LSU_RESP: state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == LSU_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_valid_q & err_q;
  assign resp_rdata_o = (resp_valid_q && !we_q && !err_q) ? load_data : '0;

  assign ram_ce_o    = ram_ce_q;
  // A reset arriving mid-WRITE must not let a half-finished merge reach RAM.
  assign ram_we_o    = ram_we_q & ~rst_i;
  assign ram_raddr_o = {addr_q[63:3], 3'b000};
  assign ram_waddr_o = {addr_q[63:3], 3'b000};
  assign ram_wdata_o = merged;

endmodule
